temp_pingpong_ram: RTL

Double-buffered (ping-pong) coefficient store for the polynomial datapath: two distributed-RAM banks, a producer filling one bank while a consumer reads the other, with a commit/release handshake and an optional hardware zero-fill of each released bank. It is the parametrised successor of the single-bank temp RAMs: width, depth and read latency are configurable, and it adds bank ownership tracking and clearing. It sits between a coefficient-producing stage (e.g. multiplier/reduction) and the next consuming stage.

---
 rtl/temp_pingpong_ram_pkg.sv | 20 ++
 rtl/temp_pingpong_ram_if.sv | 32 +++
 rtl/temp_pingpong_ram_dist_ram_bank.sv | 28 ++
 rtl/temp_pingpong_ram.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/temp_pingpong_ram_pkg.sv
// Shared constants and clear-FSM state type for the ping-pong coefficient store.
package temp_ram_pkg;

  localparam int unsigned TEMP_RAM_WIDTH     = 13;
  localparam int unsigned TEMP_RAM_ADDR_BITS = 11;
  localparam int unsigned TEMP_DEPTH         = 761;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    INIT0 = 2'd2,
    INIT1 = 2'd3
  } clr_state_t;

  // True while the post-reset sweep of both banks is running.
  function automatic logic is_init(input clr_state_t s);
    return (s == INIT0) || (s == INIT1);
  endfunction

endpackage

// File: rtl/temp_pingpong_ram_if.sv
// Producer/consumer bus of the ping-pong coefficient store.
interface temp_pingpong_ram_if
  import temp_ram_pkg::*;
#(
  parameter int unsigned RAM_WIDTH     = TEMP_RAM_WIDTH,
  parameter int unsigned RAM_ADDR_BITS = TEMP_RAM_ADDR_BITS
);

  logic                     wr_en;
  logic [RAM_ADDR_BITS-1:0] wr_addr;
  logic [RAM_WIDTH-1:0]     wr_data;
  logic                     wr_commit;
  logic                     wr_ready;
  logic [RAM_ADDR_BITS-1:0] rd_addr;
  logic [RAM_WIDTH-1:0]     rd_data;
  logic                     rd_avail;
  logic                     rd_release;
  logic                     clr_busy;

  // Producer and consumer side (drives strobes, addresses and write data).
  modport master (
    output wr_en, wr_addr, wr_data, wr_commit, rd_addr, rd_release,
    input  wr_ready, rd_data, rd_avail, clr_busy
  );

  // Storage side.
  modport slave (
    input  wr_en, wr_addr, wr_data, wr_commit, rd_addr, rd_release,
    output wr_ready, rd_data, rd_avail, clr_busy
  );

endinterface

// File: rtl/temp_pingpong_ram_dist_ram_bank.sv
// Single-write, asynchronous-read distributed RAM bank.
module dist_ram_bank
  import temp_ram_pkg::*;
#(
  parameter int unsigned WIDTH     = TEMP_RAM_WIDTH,
  parameter int unsigned ADDR_BITS = TEMP_RAM_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  (* ram_style = "distributed" *)
  logic [WIDTH-1:0] mem [0:(2**ADDR_BITS)-1];

  // Synchronous write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/temp_pingpong_ram.sv
// Double-buffered coefficient store: producer fills one bank while the
// consumer reads the other, with commit/release handover and zero-fill.
module temp_pingpong_ram
  import temp_ram_pkg::*;
#(
  parameter int unsigned RAM_WIDTH        = TEMP_RAM_WIDTH,
  parameter int unsigned RAM_ADDR_BITS    = TEMP_RAM_ADDR_BITS,
  parameter int unsigned DEPTH            = TEMP_DEPTH,
  parameter int unsigned REG_OUT          = 0,
  parameter int unsigned CLEAR_ON_RELEASE = 1
) (
  input  logic               clk,
  input  logic               rst,
  temp_pingpong_ram_if.slave bus
);

  localparam logic [RAM_ADDR_BITS:0]   DEPTH_EXT   = (RAM_ADDR_BITS + 1)'(DEPTH);
  localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR   = RAM_ADDR_BITS'(DEPTH - 1);
  localparam clr_state_t               RESET_STATE = (CLEAR_ON_RELEASE != 0) ? INIT0 : IDLE;

  logic                     wr_bank;
  logic                     rd_bank;
  logic [1:0]               full;
  logic [1:0]               full_nxt;
  clr_state_t               state;
  logic [RAM_ADDR_BITS-1:0] clr_addr;
  logic                     clr_bank;

  logic clr_busy;
  logic wr_ready;
  logic rd_avail;
  logic commit_ok;
  logic release_ok;
  logic wr_ok;
  logic clr_last;

  logic [RAM_WIDTH-1:0] bank_rd [2];
  logic [RAM_WIDTH-1:0] rd_mux;

  assign clr_busy = (state != IDLE);
  // The init sweep covers both banks, so the producer is held off for the
  // whole sweep rather than only while its own bank is the clear target.
  assign wr_ready = !full[wr_bank] &&
                    !(clr_busy && (is_init(state) || (clr_bank == wr_bank)));
  assign rd_avail = full[rd_bank];

  assign commit_ok  = bus.wr_commit && wr_ready;
  assign release_ok = bus.rd_release && rd_avail && !clr_busy;
  assign wr_ok      = bus.wr_en && wr_ready && ({1'b0, bus.wr_addr} < DEPTH_EXT);
  assign clr_last   = (clr_addr == LAST_ADDR);

  assign bus.wr_ready = wr_ready;
  assign bus.rd_avail = rd_avail;
  assign bus.clr_busy = clr_busy;

  // Next full flags: commit marks the write bank, release frees the read bank.
  always_comb begin
    full_nxt = full;
    if (commit_ok) begin
      full_nxt[wr_bank] = 1'b1;
    end
    if (release_ok) begin
      full_nxt[rd_bank] = 1'b0;
    end
  end

  // Bank ownership pointers and full flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= '0;
    end else begin
      if (commit_ok) begin
        wr_bank <= ~wr_bank;
      end
      if (release_ok) begin
        rd_bank <= ~rd_bank;
      end
      full <= full_nxt;
    end
  end

  // Clear FSM: one zero word per cycle over addresses 0..DEPTH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RESET_STATE;
      clr_addr <= '0;
      clr_bank <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (release_ok && (CLEAR_ON_RELEASE != 0)) begin
            state    <= CLEAR;
            clr_bank <= rd_bank;
            clr_addr <= '0;
          end
        end
        CLEAR, INIT0, INIT1: begin
          if (clr_last) begin
            clr_addr <= '0;
            if (state == INIT0) begin
              state    <= INIT1;
              clr_bank <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-bank write port: clear sweep wins over the producer.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic                     clr_hit;
    logic                     prod_hit;
    logic                     we;
    logic [RAM_ADDR_BITS-1:0] waddr;
    logic [RAM_WIDTH-1:0]     wdata;

    assign clr_hit  = clr_busy && (clr_bank == 1'(b));
    assign prod_hit = wr_ok && (wr_bank == 1'(b));
    assign we       = clr_hit || prod_hit;
    assign waddr    = clr_hit ? clr_addr : bus.wr_addr;
    assign wdata    = clr_hit ? '0 : bus.wr_data;

    dist_ram_bank #(
      .WIDTH     (RAM_WIDTH),
      .ADDR_BITS (RAM_ADDR_BITS)
    ) u_bank (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (bus.rd_addr),
      .rdata (bank_rd[b])
    );
  end

  assign rd_mux = bank_rd[rd_bank];

  if (REG_OUT != 0) begin : g_rd_reg
    logic [RAM_WIDTH-1:0] rd_q;

    // Registered read: bank select and address sampled at the edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_mux;
      end
    end

    assign bus.rd_data = rd_q;
  end else begin : g_rd_comb
    assign bus.rd_data = rd_mux;
  end

endmodule
